// File: rtl/imem_loader_if.sv
// Byte-stream and imem write-port bundle for the boot loader (loader side = slave).
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, error
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: count header, little-endian words, optional
// trailing XOR checksum when LOADER_CHECKSUM_EN is defined; holds the core in reset until loaded.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave ldr
);

  // state | meaning: LEN0 low count byte | LEN1 high count byte | DATA word bytes |
  // CSUM checksum bytes | DONE core released | ERR load rejected
  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_END = S_CSUM;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t        r_state, w_next;
  logic [15:0]   r_len;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_bcnt;
  logic [23:0]   r_hold;
  logic          r_we;
  logic [31:0]   r_waddr;
  logic [31:0]   r_wdata;
  logic          r_cpu_reset;
  logic          r_done;
  logic          r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   r_xor;
`endif

  logic          w_ready;
  logic          w_xfer;
  logic [15:0]   w_n;
  logic          w_last_word;
  logic [31:0]   w_word;

  assign w_xfer      = ldr.in_valid & w_ready;
  assign w_n         = {ldr.in_data, r_len[7:0]};
  assign w_last_word = ({{(16-AW){1'b0}}, r_idx} == (r_len - 16'd1));
  assign w_word      = {ldr.in_data, r_hold};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LEN0;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      S_LEN0: begin
        w_ready = 1'b1;
        if (w_xfer) w_next = S_LEN1;
      end
      S_LEN1: begin
        w_ready = 1'b1;
        if (w_xfer) begin
          if (w_n > 16'(DEPTH)) w_next = S_ERR;
          else if (w_n == 16'd0) w_next = S_END;
          else                   w_next = S_DATA;
        end
      end
      S_DATA: begin
        w_ready = 1'b1;
        if (w_xfer && (r_bcnt == 2'd3) && w_last_word) w_next = S_END;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        w_ready = 1'b1;
        if (w_xfer && (r_bcnt == 2'd3)) w_next = (w_word == r_xor) ? S_DONE : S_ERR;
      end
`endif
      S_DONE:  w_next = S_DONE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len       <= '0;
      r_idx       <= '0;
      r_bcnt      <= '0;
      r_hold      <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      // release is delayed one edge past DONE entry so the last write lands first
      if (r_state == S_DONE) begin
        r_done      <= 1'b1;
        r_cpu_reset <= 1'b0;
      end
      if (r_state == S_ERR) r_error <= 1'b1;
      if (w_xfer) begin
        case (r_state)
          S_LEN0: r_len[7:0]  <= ldr.in_data;
          S_LEN1: r_len[15:8] <= ldr.in_data;
          S_DATA: begin
            r_hold <= {ldr.in_data, r_hold[23:8]};
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= w_word;
              r_waddr <= {{(30-AW){1'b0}}, r_idx, 2'b00};
              r_idx   <= r_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
              r_xor   <= r_xor ^ w_word;
`endif
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: begin
            r_hold <= {ldr.in_data, r_hold[23:8]};
            r_bcnt <= r_bcnt + 2'd1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign ldr.in_ready   = w_ready;
  assign ldr.imem_we    = r_we;
  assign ldr.imem_waddr = r_waddr;
  assign ldr.imem_wdata = r_wdata;
  assign ldr.cpu_reset  = r_cpu_reset;
  assign ldr.done       = r_done;
  assign ldr.error      = r_error;

endmodule
